sd_spi_responder: RTL and testbench



---
 rtl/sd_spi_pkg.sv | 22 ++
 rtl/sd_crc7.sv | 16 +
 rtl/sd_spi_responder.sv | 189 ++++++++++++++++++
 tb/tb_sd_spi_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: command indices, R1 bit positions, response lengths and FSM encoding for the SD SPI responder
package sd_spi_pkg;
    localparam logic [5:0] CMD_GO_IDLE         = 6'd0;
    localparam logic [5:0] CMD_SEND_IF_COND    = 6'd8;
    localparam logic [5:0] CMD_READ_SINGLE     = 6'd17;
    localparam logic [5:0] CMD_SD_SEND_OP_COND = 6'd41;
    localparam logic [5:0] CMD_APP_CMD         = 6'd55;
    localparam logic [5:0] CMD_READ_OCR        = 6'd58;

    localparam int R1_IDLE    = 0;
    localparam int R1_ILLEGAL = 2;
    localparam int R1_CRC_ERR = 3;

    localparam logic [5:0] RESP_LEN_R1   = 6'd8;
    localparam logic [5:0] RESP_LEN_LONG = 6'd40;

    localparam logic [2:0] ST_HUNT   = 3'd0;
    localparam logic [2:0] ST_RECV   = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_NCR    = 3'd3;
    localparam logic [2:0] ST_SEND   = 3'd4;
endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 (x^7+x^3+1), one bit per enabled clock, MSB first
module sd_crc7 (
    input  logic       control_clk_i,
    input  logic       control_rst_i,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);
    logic fb;
    assign fb = din ^ crc[6];
    always_ff @(posedge control_clk_i or posedge control_rst_i)
        if (control_rst_i) crc <= '0;
        else if (clr)      crc <= '0;
        else if (en)       crc <= {crc[5:0], 1'b0} ^ {3'b0, fb, 2'b0, fb};
endmodule

// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SPI-mode SD card model answering the init sequence with R1/R3/R7 responses
module sd_spi_responder
    import sd_spi_pkg::*;
#(
    parameter int          ACMD41_BUSY_CNT = 2,
    parameter logic [23:0] OCR_VDD         = 24'hFF8000,
    parameter logic        CCS             = 1'b1,
    parameter logic [3:0]  VHS_OK          = 4'h1,
    parameter int          SYNC_STAGES     = 2
) (
    input  logic        control_clk_i,
    input  logic        control_rst_i,
    input  logic        spi_sck_i,
    input  logic        spi_mosi_i,
    input  logic        spi_cs_n_i,
    output logic        spi_miso_o,
    output logic        card_ready_o,
    output logic        cmd_valid_o,
    output logic [5:0]  cmd_index_o,
    output logic [31:0] cmd_arg_o,
    output logic        crc_err_o
);
    localparam logic [7:0] BUSY_MAX = 8'(ACMD41_BUSY_CNT);

    logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
    logic        sck, mosi, cs_n, sck_q, rise, fall, start;
    logic [2:0]  state;
    logic [5:0]  bit_cnt, tx_len;
    logic [46:0] shreg;
    logic [39:0] resp;
    logic [7:0]  busy_cnt;
    logic        app_flag;
    logic [6:0]  crc_val;

    always_ff @(posedge control_clk_i or posedge control_rst_i)
        if (control_rst_i) begin
            sck_sync  <= '0;
            mosi_sync <= '1;
            cs_sync   <= '1;
            sck_q     <= 1'b0;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                sck_sync[i]  <= sck_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
                cs_sync[i]   <= cs_sync[i-1];
            end
            sck_sync[0]  <= spi_sck_i;
            mosi_sync[0] <= spi_mosi_i;
            cs_sync[0]   <= spi_cs_n_i;
            sck_q        <= sck;
        end

    assign sck   = sck_sync[SYNC_STAGES-1];
    assign mosi  = mosi_sync[SYNC_STAGES-1];
    assign cs_n  = cs_sync[SYNC_STAGES-1];
    assign rise  = sck & ~sck_q;
    assign fall  = ~sck & sck_q;
    assign start = state == ST_HUNT && !cs_n && rise && !mosi;

    // The start bit is fed to the CRC as it is detected; frame bits 47:8 follow while bit_cnt < 40.
    sd_crc7 u_crc (
        .control_clk_i(control_clk_i),
        .control_rst_i(control_rst_i),
        .clr          (state == ST_HUNT && !start),
        .en           (start || (state == ST_RECV && rise && bit_cnt < 6'd40)),
        .din          (mosi),
        .crc          (crc_val)
    );

    logic [5:0]  idx;
    logic [31:0] arg;
    logic        idle, crc_bad, ready_n, app_n;
    logic [7:0]  r1, busy_n;
    logic [3:0]  vhs;
    logic [5:0]  len_n;
    logic [39:0] resp_n;

    assign idx  = shreg[45:40];
    assign arg  = shreg[39:8];
    assign idle = ~card_ready_o;

    always_comb begin
        r1          = 8'h00;
        r1[R1_IDLE] = idle;
        len_n       = RESP_LEN_R1;
        ready_n     = card_ready_o;
        busy_n      = busy_cnt;
        app_n       = 1'b0;
        crc_bad     = (idx == CMD_GO_IDLE || idx == CMD_SEND_IF_COND) && crc_val != shreg[7:1];
        vhs         = arg[11:8] == VHS_OK ? VHS_OK : 4'h0;
        if (crc_bad) begin
            r1[R1_CRC_ERR] = 1'b1;
            app_n          = app_flag;
        end else if (idx == CMD_GO_IDLE) begin
            r1[R1_IDLE] = 1'b1;
            ready_n     = 1'b0;
            busy_n      = 8'd0;
        end else if (idx == CMD_SEND_IF_COND || idx == CMD_READ_OCR) begin
            len_n = RESP_LEN_LONG;
        end else if (idx == CMD_APP_CMD) begin
            app_n = 1'b1;
        end else if (idx == CMD_SD_SEND_OP_COND && app_flag) begin
            r1[R1_IDLE] = busy_cnt < BUSY_MAX;
            busy_n      = busy_cnt < BUSY_MAX ? busy_cnt + 8'd1 : busy_cnt;
            ready_n     = busy_cnt >= BUSY_MAX;
        end else begin
            r1[R1_ILLEGAL] = 1'b1;
        end
        resp_n = len_n == RESP_LEN_R1      ? {r1, 32'h0} :
                 idx == CMD_SEND_IF_COND   ? {r1, 20'h0, vhs, arg[7:0]} :
                                             {r1, card_ready_o, CCS & card_ready_o, 6'b0, OCR_VDD};
    end

    always_ff @(posedge control_clk_i or posedge control_rst_i)
        if (control_rst_i) begin
            state        <= ST_HUNT;
            spi_miso_o   <= 1'b1;
            card_ready_o <= 1'b0;
            cmd_valid_o  <= 1'b0;
            crc_err_o    <= 1'b0;
            cmd_index_o  <= '0;
            cmd_arg_o    <= '0;
            busy_cnt     <= '0;
            app_flag     <= 1'b0;
            shreg        <= '0;
            resp         <= '0;
            bit_cnt      <= '0;
            tx_len       <= '0;
        end else begin
            cmd_valid_o <= 1'b0;
            crc_err_o   <= 1'b0;
            if (cs_n && state != ST_HUNT && state != ST_DECODE) begin
                state      <= ST_HUNT;
                spi_miso_o <= 1'b1;
            end else begin
                case (state)
                    ST_HUNT: begin
                        spi_miso_o <= 1'b1;
                        if (start) begin
                            shreg   <= '0;
                            bit_cnt <= 6'd1;
                            state   <= ST_RECV;
                        end
                    end
                    ST_RECV: if (rise) begin
                        shreg   <= {shreg[45:0], mosi};
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd47) state <= ST_DECODE;
                    end
                    ST_DECODE: begin
                        bit_cnt <= '0;
                        // Transmission bit 46 and stop bit 0 must both be 1, else the frame is dropped silently.
                        if (shreg[46] && shreg[0]) begin
                            cmd_valid_o  <= 1'b1;
                            crc_err_o    <= crc_bad;
                            cmd_index_o  <= idx;
                            cmd_arg_o    <= arg;
                            resp         <= resp_n;
                            tx_len       <= len_n;
                            card_ready_o <= ready_n;
                            busy_cnt     <= busy_n;
                            app_flag     <= app_n;
                            state        <= ST_NCR;
                        end else begin
                            state <= ST_HUNT;
                        end
                    end
                    ST_NCR: begin
                        spi_miso_o <= 1'b1;
                        if (fall) begin
                            bit_cnt <= bit_cnt == 6'd7 ? 6'd0 : bit_cnt + 6'd1;
                            if (bit_cnt == 6'd7) state <= ST_SEND;
                        end
                    end
                    ST_SEND: if (fall) begin
                        if (bit_cnt == tx_len) begin
                            spi_miso_o <= 1'b1;
                            state      <= ST_HUNT;
                        end else begin
                            spi_miso_o <= resp[39];
                            resp       <= {resp[38:0], 1'b0};
                            bit_cnt    <= bit_cnt + 6'd1;
                        end
                    end
                    default: state <= ST_HUNT;
                endcase
            end
        end
endmodule

// File: tb/tb_sd_spi_responder.sv
// tb_sd_spi_responder: directed SD init sequence with a byte scoreboard on MISO
module tb_sd_spi_responder;
    localparam int HALF = 8;
    localparam logic [47:0] F_CMD0     = 48'h400000000095;
    localparam logic [47:0] F_CMD0_BAD = 48'h400000000001;
    localparam logic [47:0] F_CMD8     = 48'h48000001AA87;
    localparam logic [47:0] F_CMD8_BAD = 48'h48000001AA01;

    logic clk = 0, rst = 1, sck = 0, mosi = 1, cs_n = 1;
    logic miso, ready, valid, crc_err;
    logic [5:0] index;
    logic [31:0] arg;

    int checks = 0, errors = 0;
    int vcnt = 0, ecnt = 0, exp_valid = 0, exp_err = 0;
    logic [5:0] last_idx = '0;
    logic [7:0] exp_q[$];

    sd_spi_responder dut (
        .control_clk_i(clk), .control_rst_i(rst),
        .spi_sck_i(sck), .spi_mosi_i(mosi), .spi_cs_n_i(cs_n), .spi_miso_o(miso),
        .card_ready_o(ready), .cmd_valid_o(valid), .cmd_index_o(index),
        .cmd_arg_o(arg), .crc_err_o(crc_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) begin
            vcnt++;
            last_idx = index;
        end
        if (crc_err) ecnt++;
    end

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c = '0;
        for (int i = 39; i >= 0; i--) c = {c[5:0], 1'b0} ^ ((d[i] ^ c[6]) ? 7'h09 : 7'h00);
        return c;
    endfunction

    function automatic logic [47:0] mk(input logic [5:0] i, input logic [31:0] a);
        logic [39:0] d = {2'b01, i, a};
        return {d, crc7(d), 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic shift(input logic [47:0] tx, input int n, output logic [47:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            sck = 1;
            rx = {rx[46:0], miso};
            repeat (HALF) @(negedge clk);
            sck = 0;
        end
        mosi = 1;
    endtask

    task automatic drain(input string tag);
        logic [47:0] r;
        while (exp_q.size() > 0) begin
            shift(48'hFF, 8, r);
            chk(tag, r[7:0], exp_q.pop_front());
        end
    endtask

    task automatic run(input string tag, input logic [47:0] f);
        logic [47:0] r;
        shift(f, 48, r);
        exp_valid++;
        drain({tag, " resp"});
        chk({tag, " valid"}, vcnt, exp_valid);
        chk({tag, " index"}, last_idx, f[45:40]);
        chk({tag, " crcerr"}, ecnt, exp_err);
    endtask

    task automatic r1(input string tag, input logic [47:0] f, input logic [7:0] b);
        exp_q.push_back(8'hFF);
        exp_q.push_back(b);
        exp_q.push_back(8'hFF);
        run(tag, f);
    endtask

    task automatic r5(input string tag, input logic [47:0] f, input logic [39:0] v);
        exp_q.push_back(8'hFF);
        for (int i = 4; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
        exp_q.push_back(8'hFF);
        run(tag, f);
    endtask

    task automatic ready_seq(input string tag);
        r1({tag, " cmd55a"}, mk(6'd55, 32'h0), 8'h01);
        r1({tag, " acmd41a"}, mk(6'd41, 32'h40000000), 8'h01);
        r1({tag, " cmd55b"}, mk(6'd55, 32'h0), 8'h01);
        r1({tag, " acmd41b"}, mk(6'd41, 32'h40000000), 8'h01);
        chk({tag, " still busy"}, ready, 0);
        r1({tag, " cmd55c"}, mk(6'd55, 32'h0), 8'h01);
        r1({tag, " acmd41c"}, mk(6'd41, 32'h40000000), 8'h00);
        chk({tag, " ready"}, ready, 1);
    endtask

    initial begin
        logic [47:0] r, f;
        repeat (3) @(negedge clk);
        chk("rst miso", miso, 1);
        chk("rst ready", ready, 0);
        chk("rst valid", valid, 0);
        chk("rst crcerr", crc_err, 0);
        chk("rst index", index, 0);
        chk("rst arg", arg, 0);
        rst = 0;
        repeat (4) @(negedge clk);
        cs_n = 0;
        repeat (4) @(negedge clk);

        r1("cmd0", F_CMD0, 8'h01);
        r5("cmd8", F_CMD8, 40'h01000001AA);
        chk("cmd8 arg", arg, 32'h1AA);
        exp_err++;
        r1("cmd8 badcrc", F_CMD8_BAD, 8'h09);
        r1("cmd41 noapp", mk(6'd41, 32'h0), 8'h05);

        r1("cmd55 keep", mk(6'd55, 32'h0), 8'h01);
        exp_err++;
        r1("cmd0 badcrc", F_CMD0_BAD, 8'h09);
        r1("acmd41 kept", mk(6'd41, 32'h40000000), 8'h01);
        chk("acmd41 arg", arg, 32'h40000000);
        r1("cmd55 b", mk(6'd55, 32'h0), 8'h01);
        r1("acmd41 b", mk(6'd41, 32'h40000000), 8'h01);
        chk("busy ready", ready, 0);
        r1("cmd55 c", mk(6'd55, 32'h0), 8'h01);
        r1("acmd41 c", mk(6'd41, 32'h40000000), 8'h00);
        chk("ready up", ready, 1);
        r5("cmd58", mk(6'd58, 32'h0), 40'h00C0FF8000);
        r1("cmd17 ready", mk(6'd17, 32'h0), 8'h04);

        f = F_CMD0;
        shift({28'b0, f[47:28]}, 20, r);
        cs_n = 1;
        shift(48'hFFFF, 16, r);
        chk("abort miso", r[15:0], 16'hFFFF);
        chk("abort valid", vcnt, exp_valid);
        chk("abort keeps ready", ready, 1);

        shift(F_CMD0, 48, r);
        shift(48'hFFFFFF, 24, r);
        chk("cs high miso", r[23:0], 24'hFFFFFF);
        chk("cs high valid", vcnt, exp_valid);
        cs_n = 0;
        repeat (4) @(negedge clk);

        r1("cmd0 after abort", F_CMD0, 8'h01);
        chk("cmd0 clears ready", ready, 0);
        r1("cmd17 idle", mk(6'd17, 32'h0), 8'h05);

        ready_seq("again");
        shift(mk(6'd58, 32'h0), 48, r);
        exp_valid++;
        shift(48'hFF, 8, r);
        chk("ncr byte", r[7:0], 8'hFF);
        shift(48'h7, 3, r);
        repeat (4) @(negedge clk);
        chk("mid send miso", miso, 0);
        chk("mid send valid", vcnt, exp_valid);
        rst = 1;
        #1;
        chk("async rst miso", miso, 1);
        chk("async rst ready", ready, 0);
        chk("async rst index", index, 0);
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (4) @(negedge clk);
        r1("cmd17 after rst", mk(6'd17, 32'h0), 8'h05);
        r1("acmd41 after rst", mk(6'd41, 32'h0), 8'h05);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
